// File: rtl/game_score_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_score_ctrl
//  Brief    : Game sequencer (IDLE/RUN/OVER) driven by the divider's game
//             tick; tracks score, lives, steps and level-up strobes, and
//             feeds the saturated score back to set the divider period.
//  Options  : define SCORE_BCD_EN to add the 3-digit BCD score output.
//  Revision : 1.0 - initial release
// ============================================================================
module game_score_ctrl #(
   parameter int MAX_SCORE = 999,
   parameter int LIVES     = 3,
   parameter int LIVES_W   = 2,
   parameter int LEVEL_PTS = 10
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               tick,
   input  logic               start,
   input  logic               pause,
   input  logic               hit,
   input  logic               miss,
   output logic [9:0]         score,
   output logic [LIVES_W-1:0] lives,
   output logic [1:0]         state,
   output logic               step,
   output logic               level_up,
   output logic [15:0]        steps
`ifdef SCORE_BCD_EN
   ,
   output logic [11:0]        score_bcd
`endif
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_OVER = 2'd2;

   localparam int                 c_LVL_W    = $clog2(LEVEL_PTS + 1);
   localparam logic [9:0]         c_MAX      = 10'(MAX_SCORE);
   localparam logic [LIVES_W-1:0] c_LIVES    = LIVES_W'(LIVES);
   localparam logic [LIVES_W-1:0] c_ONE      = LIVES_W'(1);
   localparam logic [c_LVL_W-1:0] c_LVL_LAST = c_LVL_W'(LEVEL_PTS - 1);

   logic [1:0]         r_state, w_state_nxt;
   logic [9:0]         r_score, w_score_nxt;
   logic [LIVES_W-1:0] r_lives, w_lives_nxt;
   logic [15:0]        r_steps, w_steps_nxt;
   logic [c_LVL_W-1:0] r_lvl,   w_lvl_nxt;
   logic               r_step,  w_step_nxt;
   logic               r_lvlup, w_lvlup_nxt;
   logic [11:0]        r_bcd,   w_bcd_nxt;

   // A start request from any legal state restarts the game; in the illegal
   // state it is ignored so recovery to IDLE is unconditional.
   logic w_clear;
   logic w_active;
   assign w_clear  = start && (r_state != 2'd3);
   assign w_active = (r_state == c_RUN) && !start && !pause;

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) r_state <= c_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode: start wins, then pause, then the final-life miss
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (start) w_state_nxt = c_RUN;
         c_RUN: begin
            if (start)
               w_state_nxt = c_RUN;
            else if (!pause && miss && (r_lives == c_ONE))
               w_state_nxt = c_OVER;
         end
         c_OVER:  if (start) w_state_nxt = c_RUN;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Output/datapath decode: strobes default low, counters hold unless active
   always_comb begin
      w_score_nxt = r_score;
      w_lives_nxt = r_lives;
      w_steps_nxt = r_steps;
      w_lvl_nxt   = r_lvl;
      w_bcd_nxt   = r_bcd;
      w_step_nxt  = 1'b0;
      w_lvlup_nxt = 1'b0;
      if (w_clear) begin
         w_score_nxt = 10'd0;
         w_lives_nxt = c_LIVES;
         w_steps_nxt = 16'd0;
         w_lvl_nxt   = '0;
         w_bcd_nxt   = 12'd0;
      end else if (w_active) begin
         if (tick) begin
            w_step_nxt  = 1'b1;
            w_steps_nxt = r_steps + 16'd1;
         end
         // Saturated hits are not counted toward the level either
         if (hit && (r_score < c_MAX)) begin
            w_score_nxt = r_score + 10'd1;
            if (r_lvl == c_LVL_LAST) begin
               w_lvl_nxt   = '0;
               w_lvlup_nxt = 1'b1;
            end else begin
               w_lvl_nxt = r_lvl + 1'b1;
            end
            // Decimal ripple increment; the score cap keeps hundreds <= 9
            if (r_bcd[3:0] == 4'd9) begin
               w_bcd_nxt[3:0] = 4'd0;
               if (r_bcd[7:4] == 4'd9) begin
                  w_bcd_nxt[7:4]  = 4'd0;
                  w_bcd_nxt[11:8] = r_bcd[11:8] + 4'd1;
               end else begin
                  w_bcd_nxt[7:4] = r_bcd[7:4] + 4'd1;
               end
            end else begin
               w_bcd_nxt[3:0] = r_bcd[3:0] + 4'd1;
            end
         end
         if (miss && (r_lives != '0))
            w_lives_nxt = r_lives - c_ONE;
      end
   end

   // Datapath registers, all outputs come straight from flops
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_score <= 10'd0;
         r_lives <= c_LIVES;
         r_steps <= 16'd0;
         r_lvl   <= '0;
         r_bcd   <= 12'd0;
         r_step  <= 1'b0;
         r_lvlup <= 1'b0;
      end else begin
         r_score <= w_score_nxt;
         r_lives <= w_lives_nxt;
         r_steps <= w_steps_nxt;
         r_lvl   <= w_lvl_nxt;
         r_bcd   <= w_bcd_nxt;
         r_step  <= w_step_nxt;
         r_lvlup <= w_lvlup_nxt;
      end
   end

   assign score    = r_score;
   assign lives    = r_lives;
   assign state    = r_state;
   assign step     = r_step;
   assign level_up = r_lvlup;
   assign steps    = r_steps;
`ifdef SCORE_BCD_EN
   assign score_bcd = r_bcd;
`else
   logic w_bcd_unused;
   assign w_bcd_unused = ^r_bcd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_score_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_score_ctrl
//  Brief    : Self-checking bench for game_score_ctrl with a behavioural
//             game model and directed plus random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_score_ctrl;

   localparam int MAX_SCORE = 999;
   localparam int LIVES     = 3;
   localparam int LEVEL_PTS = 10;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        tick = 1'b0, start = 1'b0, pause = 1'b0, hit = 1'b0, miss = 1'b0;
   logic [9:0]  score;
   logic [1:0]  lives;
   logic [1:0]  state;
   logic        step, level_up;
   logic [15:0] steps;
`ifdef SCORE_BCD_EN
   logic [11:0] score_bcd;
`endif

   game_score_ctrl #(
      .MAX_SCORE(MAX_SCORE), .LIVES(LIVES), .LIVES_W(2), .LEVEL_PTS(LEVEL_PTS)
   ) dut (
      .clk(clk), .clr(clr), .tick(tick), .start(start), .pause(pause),
      .hit(hit), .miss(miss), .score(score), .lives(lives), .state(state),
      .step(step), .level_up(level_up), .steps(steps)
`ifdef SCORE_BCD_EN
      , .score_bcd(score_bcd)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural game model: whole-game quantities in plain integers
   int m_state, m_score, m_lives, m_steps, m_counted;
   int m_step, m_lu;

   function automatic int to_bcd(input int v);
      return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
   endfunction

   task automatic model_clear();
      m_score = 0; m_lives = LIVES; m_steps = 0; m_counted = 0;
   endtask

   task automatic model_reset();
      model_clear();
      m_state = 0; m_step = 0; m_lu = 0;
   endtask

   task automatic model_edge(input bit st, pa, tk, ht, ms);
      m_step = 0; m_lu = 0;
      if (st) begin
         model_clear();
         m_state = 1;
      end else if (m_state == 1 && !pa) begin
         if (tk) begin
            m_step  = 1;
            m_steps = (m_steps + 1) % 65536;
         end
         if (ht && m_score < MAX_SCORE) begin
            m_score++;
            m_counted++;
            if (m_counted % LEVEL_PTS == 0) m_lu = 1;
         end
         if (ms) begin
            m_lives--;
            if (m_lives == 0) m_state = 2;
         end
      end
   endtask

   // One clock: drive inputs, take the edge, advance the model
   task automatic cyc(input bit st, pa, tk, ht, ms);
      start = st; pause = pa; tick = tk; hit = ht; miss = ms;
      @(posedge clk);
      #1;
      model_edge(st, pa, tk, ht, ms);
      start = 0; pause = 0; tick = 0; hit = 0; miss = 0;
   endtask

   task automatic test_reset();
      #12;
      model_reset();
      vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state); end
      vectors++; if (score !== 10'd0) begin miscompares++; $display("FAIL reset_score got=%0d exp=0", score); end
      vectors++; if (lives !== 2'd3) begin miscompares++; $display("FAIL reset_lives got=%0d exp=3", lives); end
      vectors++; if (step !== 1'b0 || level_up !== 1'b0) begin miscompares++; $display("FAIL reset_strobes step=%0b lvl=%0b exp=0", step, level_up); end
      vectors++; if (steps !== 16'd0) begin miscompares++; $display("FAIL reset_steps got=%0d exp=0", steps); end
      @(negedge clk);
      clr = 0;
   endtask

   task automatic test_mid_reset();
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 1);
      vectors++; if (score !== 10'(m_score) || m_score != 5) begin miscompares++; $display("FAIL mid_pre_score got=%0d exp=5", score); end
      vectors++; if (lives !== 2'(m_lives) || m_lives != 2) begin miscompares++; $display("FAIL mid_pre_lives got=%0d exp=2", lives); end
      #2 clr = 1;
      #1;
      vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL mid_reset_state got=%0d exp=0", state); end
      vectors++; if (score !== 10'd0) begin miscompares++; $display("FAIL mid_reset_score got=%0d exp=0", score); end
      vectors++; if (lives !== 2'd3) begin miscompares++; $display("FAIL mid_reset_lives got=%0d exp=3", lives); end
      vectors++; if (steps !== 16'd0) begin miscompares++; $display("FAIL mid_reset_steps got=%0d exp=0", steps); end
      model_reset();
      @(negedge clk);
      clr = 0;
      // IDLE ignores events
      cyc(0, 0, 1, 1, 1);
      vectors++; if (state !== 2'd0 || score !== 10'd0 || step !== 1'b0) begin miscompares++; $display("FAIL idle_ignore state=%0d score=%0d step=%0b exp=0/0/0", state, score, step); end
   endtask

   task automatic test_step();
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, (i == 4), (i % 2 == 0), 0, 0);
         vectors++; if (step !== m_step[0]) begin miscompares++; $display("FAIL step_pulse[%0d] got=%0b exp=%0d", i, step, m_step); end
      end
      vectors++; if (steps !== 16'd3 || m_steps != 3) begin miscompares++; $display("FAIL step_count got=%0d exp=3", steps); end
   endtask

   task automatic test_level();
      cyc(1, 0, 0, 0, 0);
      for (int i = 1; i <= 11; i++) begin
         cyc(0, 0, 0, 1, 0);
         vectors++; if (score !== 10'(i)) begin miscompares++; $display("FAIL level_score[%0d] got=%0d exp=%0d", i, score, i); end
         vectors++; if (level_up !== (i == 10)) begin miscompares++; $display("FAIL level_up[%0d] got=%0b exp=%0b", i, level_up, (i == 10)); end
      end
   endtask

   task automatic test_saturate();
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < MAX_SCORE; i++) cyc(0, 0, 0, 1, 0);
      vectors++; if (score !== 10'd999) begin miscompares++; $display("FAIL sat_reach got=%0d exp=999", score); end
      cyc(0, 0, 0, 1, 0);
      vectors++; if (score !== 10'd999) begin miscompares++; $display("FAIL sat_hold got=%0d exp=999", score); end
      vectors++; if (level_up !== 1'b0) begin miscompares++; $display("FAIL sat_no_level got=%0b exp=0", level_up); end
`ifdef SCORE_BCD_EN
      vectors++; if (score_bcd !== 12'h999) begin miscompares++; $display("FAIL sat_bcd got=%h exp=999", score_bcd); end
`endif
   endtask

   task automatic test_gameover();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      vectors++; if (lives !== 2'd1 || state !== 2'd1) begin miscompares++; $display("FAIL over_pre lives=%0d state=%0d exp=1/1", lives, state); end
      cyc(0, 0, 0, 1, 1);
      vectors++; if (lives !== 2'd0) begin miscompares++; $display("FAIL over_lives got=%0d exp=0", lives); end
      vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL over_state got=%0d exp=2", state); end
      vectors++; if (score !== 10'd1) begin miscompares++; $display("FAIL over_score got=%0d exp=1", score); end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 1, 0);
         vectors++; if (step !== 1'b0 || steps !== 16'd0 || score !== 10'd1) begin miscompares++; $display("FAIL over_frozen step=%0b steps=%0d score=%0d exp=0/0/1", step, steps, score); end
      end
      cyc(1, 0, 0, 0, 0);
      vectors++; if (state !== 2'd1 || score !== 10'd0 || lives !== 2'd3) begin miscompares++; $display("FAIL over_restart state=%0d score=%0d lives=%0d exp=1/0/3", state, score, lives); end
   endtask

   task automatic test_restart();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1, 0);
      vectors++; if (score !== 10'd7 || steps !== 16'd7) begin miscompares++; $display("FAIL restart_pre score=%0d steps=%0d exp=7/7", score, steps); end
      cyc(1, 0, 1, 1, 1);
      vectors++; if (score !== 10'd0 || steps !== 16'd0) begin miscompares++; $display("FAIL restart_clear score=%0d steps=%0d exp=0/0", score, steps); end
      vectors++; if (lives !== 2'd3 || state !== 2'd1 || step !== 1'b0) begin miscompares++; $display("FAIL restart_state lives=%0d state=%0d step=%0b exp=3/1/0", lives, state, step); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(39) == 0), ($urandom_range(5) == 0), ($urandom_range(2) == 0),
             ($urandom_range(1) == 0), ($urandom_range(11) == 0));
         vectors++;
         if (state !== 2'(m_state) || score !== 10'(m_score) || lives !== 2'(m_lives) ||
             steps !== 16'(m_steps) || step !== m_step[0] || level_up !== m_lu[0]) begin
            miscompares++;
            $display("FAIL random[%0d] got st=%0d sc=%0d lv=%0d sp=%0d s=%0b lu=%0b exp st=%0d sc=%0d lv=%0d sp=%0d s=%0d lu=%0d",
                     i, state, score, lives, steps, step, level_up,
                     m_state, m_score, m_lives, m_steps, m_step, m_lu);
         end
`ifdef SCORE_BCD_EN
         vectors++;
         if (score_bcd !== 12'(to_bcd(m_score))) begin
            miscompares++;
            $display("FAIL random_bcd[%0d] got=%h exp=%h", i, score_bcd, to_bcd(m_score));
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_mid_reset();
      test_step();
      test_level();
      test_saturate();
      test_gameover();
      test_restart();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_score_ctrl.md
Name: game_score_ctrl

Overview:
- Consumer end of the game-rate tick interface: takes the 1-cycle game tick from the clock divider and produces the 10-bit score that sets the divider's tick period.
- Sequences the game (IDLE/RUN/OVER), counts hits and lives, issues a per-step strobe to game logic, and raises level-up strobes.
- Score is capped so the divider period never reaches zero.

Parameters:
- MAX_SCORE, 999, saturation ceiling for score; keeps divider period positive.
- LIVES, 3, lives loaded on start.
- LIVES_W, 2, width of the lives output.
- LEVEL_PTS, 10, number of counted hits per level_up pulse.

Ports:
- clk  in  1  system clock, 50 MHz
- clr  in  1  reset
- tick  in  1  game tick, 1-cycle pulse synchronous to clk
- start  in  1  start/restart request, sampled every cycle
- pause  in  1  level; freezes RUN activity
- hit  in  1  point event, 1-cycle pulse
- miss  in  1  life-loss event, 1-cycle pulse
- score  out  10  current score, fed back to clock divider
- lives  out  LIVES_W  remaining lives
- state  out  2  0=IDLE, 1=RUN, 2=OVER
- step  out  1  1-cycle strobe, game logic advances one step
- level_up  out  1  1-cycle strobe on completing LEVEL_PTS hits
- steps  out  16  steps elapsed since start

Behaviour:
- Reset clr is asynchronous, active-high; clock is clk. Reset is honoured mid-game.
- All outputs are registered. Reset values:
  - state=IDLE, score=0, lives=LIVES, step=0, level_up=0, steps=0.
  - Internal level counter = 0.
- IDLE:
  - tick, hit and miss are ignored.
  - start=1 -> RUN on the next edge, with score=0, lives=LIVES, steps=0 and level counter=0.
- RUN, ordinary cycle:
  - Priority order: start, then pause, then events.
  - start=1 restarts the game: same clears as from IDLE; state stays RUN; all other inputs in that cycle are ignored.
- RUN, pause=1:
  - tick, hit and miss are ignored; no step; all counters hold.
- RUN, pause=0:
  - tick=1 -> step=1 in the following cycle (latency 1, exactly one cycle wide); steps increments in the same cycle and wraps 0xFFFF -> 0.
  - hit=1 and score<MAX_SCORE -> score+1 and level counter+1.
  - When the level counter reaches LEVEL_PTS, it resets to 0 and level_up=1 the following cycle for one cycle.
  - hit at score==MAX_SCORE: score holds, level counter holds, no level_up.
  - miss=1 -> lives-1. If lives==1 before decrement: lives=0 and state=OVER on the same edge.
  - hit and miss in the same cycle: both are applied. A final-life miss still moves to OVER; the hit still counts and may fire level_up.
  - tick coincident with the final-life miss: step still fires the next cycle, and steps still increments.
- OVER:
  - score, lives and steps frozen; step and level_up stay 0.
  - start=1 -> RUN with the same clears as from IDLE.
- state value 3 is unreachable; if entered, go to IDLE on the next edge.
- score is never written above MAX_SCORE; arithmetic is unsigned 10-bit.

Optional Feature:
- Macro: SCORE_BCD_EN.
- Defined: adds output score_bcd [11:0], three BCD digits (hundreds, tens, ones).
  - Maintained incrementally: ones wrap 9->0 with carry into tens, tens into hundreds.
  - Cleared wherever score is cleared; holds at saturation.
  - Always equals score in decimal, with the same timing as score.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RUN: score=5, lives=2, assert clr asynchronously between edges -> state=0, score=0, lives=3, steps=0 immediately, without waiting for a clk edge.
- start, then 4 ticks, with pause=1 during the 3rd tick -> exactly 3 step pulses, each one cycle after its tick; steps=3.
- start, then 10 hits -> score=10, level_up high one cycle after the 10th hit. 11th hit -> score=11, no level_up.
- Preload 999 via hits (MAX_SCORE=999), one more hit -> score stays 999, no level_up; with SCORE_BCD_EN, score_bcd=0x999.
- 3 misses, the 3rd coincident with a hit -> lives=0, state=2 on that edge, score incremented. Further ticks give no step; then start -> state=1, score=0, lives=3.
- start asserted during RUN with score=7 -> score=0, steps=0, lives=3, state stays 1.
